// File: rtl/sampling_pkg.sv
// Shared definitions for the up/down sampling blocks:
// default frame geometry, FSM encoding and counter sizing.
package sampling_pkg;

  localparam int IN_WIDTH_DEF   = 400;
  localparam int IN_HEIGHT_DEF  = 300;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } samp_state_e;

  // A range of one still needs a one-bit counter.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/upsampler_linebuf.sv
// One-line pixel store for the upsampler:
// synchronous write, combinational read, no reset.
module upsampler_linebuf
  import sampling_pkg::*;
#(
  parameter int DEPTH = IN_WIDTH_DEF,
  parameter int DW    = DATA_WIDTH_DEF,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsampler.sv
// 2x pixel-replicating upsampler: each pixel is shown twice
// while the line is filled, then the stored line is replayed.
module upsampler
  import sampling_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int IN_HEIGHT  = IN_HEIGHT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  validout,
  output logic                  blankingregion
);

  localparam int CW = cnt_width(IN_WIDTH);
  localparam int RW = cnt_width(IN_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

  samp_state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] col_nxt, raddr;
  logic [RW-1:0] row_q, row_d;
  logic phase_q, phase_d;
  logic eol_q, eol_d;
  logic vout_q, vout_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic accept;

  // eol_q keeps ready low while the last pixel's second copy shows.
  assign ready = (state_q == BLANK) ||
                 (state_q == FILL && !phase_q && !eol_q);
  assign accept = valid && ready;

  assign col_nxt = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign raddr   = (state_q == REPLAY) ? col_nxt : '0;

  assign blankingregion = (state_q == BLANK);
  assign validout = vout_q;
  assign dataout  = dout_q;

  upsampler_linebuf #(
    .DEPTH (IN_WIDTH),
    .DW    (DATA_WIDTH),
    .AW    (CW)
  ) u_linebuf (
    .clk_i   (clock),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    eol_d   = eol_q;
    vout_d  = vout_q;
    dout_d  = dout_q;

    unique case (state_q)
      BLANK: begin
        vout_d = 1'b0;
        if (accept) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (eol_q) begin
          state_d = REPLAY;
          eol_d   = 1'b0;
          col_d   = '0;
          dout_d  = rdata;
          vout_d  = 1'b1;
          phase_d = 1'b1;
        end else if (!accept) begin
          vout_d = 1'b0;
        end
      end
      REPLAY: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (col_q == COL_LAST) begin
          col_d  = '0;
          vout_d = 1'b0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = BLANK;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = FILL;
          end
        end else begin
          col_d   = col_nxt;
          dout_d  = rdata;
          phase_d = 1'b1;
        end
      end
      default: begin
        state_d = BLANK;
      end
    endcase

    if (accept) begin
      dout_d  = data;
      vout_d  = 1'b1;
      phase_d = 1'b1;
      eol_d   = (col_q == COL_LAST);
      col_d   = col_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BLANK;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      eol_q   <= 1'b0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      eol_q   <= eol_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_upsampler.sv
// Bench for upsampler: table-checked 4x3 frames plus a
// randomized 5x3 instance against a replicated-stream model.
module tb_upsampler;

  localparam int BW = 5;
  localparam int BH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_v, a_rdy, a_vo, a_bl;
  logic [7:0] a_d, a_do;
  logic b_v, b_rdy, b_vo, b_bl;
  logic [7:0] b_d, b_do;

  upsampler #(
    .IN_WIDTH   (4),
    .IN_HEIGHT  (3),
    .DATA_WIDTH (8)
  ) dut_a (
    .clock          (clk),
    .reset          (rst),
    .valid          (a_v),
    .data           (a_d),
    .ready          (a_rdy),
    .dataout        (a_do),
    .validout       (a_vo),
    .blankingregion (a_bl)
  );

  upsampler #(
    .IN_WIDTH   (BW),
    .IN_HEIGHT  (BH),
    .DATA_WIDTH (8)
  ) dut_b (
    .clock          (clk),
    .reset          (rst),
    .valid          (b_v),
    .data           (b_d),
    .ready          (b_rdy),
    .dataout        (b_do),
    .validout       (b_vo),
    .blankingregion (b_bl)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         in_row;
    logic [63:0] exp;
  } line_t;

  line_t tbl [6];
  logic [7:0] cap[$];
  int capcyc[$];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
    end
  endtask

  // Feeds one 4x3 frame (data = col + row) and captures outputs.
  task automatic frame_a(input int mode, input int stop_at,
                         output int ffseen, output int holdbad,
                         output bit tmo);
    int row = 0;
    int col = 0;
    int nacc = 0;
    bit acc;
    logic [7:0] last;
    cap.delete();
    capcyc.delete();
    ffseen = 0;
    holdbad = 0;
    tmo = 1'b1;
    last = a_do;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (a_vo) begin
        cap.push_back(a_do);
        capcyc.push_back(cyc);
      end else if (a_do !== last) begin
        holdbad++;
      end
      last = a_do;
      if (cap.size() == 48) begin
        a_v = 1'b0;
        tmo = 1'b0;
        return;
      end
      if (nacc == 12) begin
        a_v = 1'b0;
      end else begin
        case (mode)
          0:       a_v = 1'b1;
          1:       a_v = (cyc % 2 == 0);
          default: a_v = (cyc % 3 == 0);
        endcase
        a_d = a_rdy ? 8'(col + tbl[2*row].in_row) : 8'hFF;
        if (a_v && !a_rdy) ffseen++;
      end
      acc = a_v && a_rdy;
      @(posedge clk);
      if (acc) begin
        nacc++;
        col++;
        if (col == 4) begin
          col = 0;
          row++;
        end
      end
      if (nacc == stop_at) begin
        a_v = 1'b0;
        tmo = 1'b0;
        return;
      end
    end
    a_v = 1'b0;
  endtask

  task automatic cmp_frame(input string tag, input bit strict);
    logic [63:0] g;
    int gaps;
    int ffs;
    check({tag, "_count"}, cap.size(), 48);
    if (cap.size() != 48) return;
    ffs = 0;
    for (int l = 0; l < 6; l++) begin
      g = '0;
      gaps = 0;
      for (int j = 0; j < 8; j++) begin
        g = {g[55:0], cap[l*8+j]};
        if (cap[l*8+j] == 8'hFF) ffs++;
        if (j > 0 && capcyc[l*8+j] != capcyc[l*8+j-1] + 1) gaps++;
      end
      check($sformatf("%s_line%0d", tag, l), g, tbl[l].exp);
      if (strict) check($sformatf("%s_gap%0d", tag, l), gaps, 0);
    end
    check({tag, "_ff_out"}, ffs, 0);
  endtask

  // Model: every accepted pixel is emitted twice at once; a full
  // line is then emitted again, each pixel twice.
  task automatic rand_b(input int frames);
    logic [7:0] expq[$];
    logic [7:0] line[$];
    int acc_cnt = 0;
    int tot = 0;
    int outs = 0;
    bit acc = 1'b0;
    bit prev = 1'b0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (prev) begin
        check("b_lat_vo", b_vo, 1);
        check("b_lat_rdy", b_rdy, 0);
      end
      check("b_blank", b_bl, acc_cnt == 0);
      if (b_vo) begin
        outs++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_extra: actual=output %0h required=none", b_do);
        end else begin
          check("b_data", b_do, expq.pop_front());
        end
        if (expq.size() == 0 && acc_cnt == BW*BH) acc_cnt = 0;
      end
      if (tot == frames*BW*BH && acc_cnt == 0 && expq.size() == 0) begin
        done = 1'b1;
        break;
      end
      b_v = (tot < frames*BW*BH) && ($urandom_range(0, 3) != 0);
      b_d = 8'($urandom);
      acc = b_v && b_rdy;
      @(posedge clk);
      if (acc) begin
        expq.push_back(b_d);
        expq.push_back(b_d);
        line.push_back(b_d);
        acc_cnt++;
        tot++;
        if (line.size() == BW) begin
          foreach (line[i]) begin
            expq.push_back(line[i]);
            expq.push_back(line[i]);
          end
          line.delete();
        end
      end
      prev = acc;
    end
    b_v = 1'b0;
    check("b_finished", done, 1);
    check("b_outs", outs, frames*4*BW*BH);
    check("b_leftover", expq.size(), 0);
  endtask

  int ff, hb;
  bit tmo;

  initial begin
    tbl[0] = '{0, 64'h00_00_01_01_02_02_03_03};
    tbl[1] = '{0, 64'h00_00_01_01_02_02_03_03};
    tbl[2] = '{1, 64'h01_01_02_02_03_03_04_04};
    tbl[3] = '{1, 64'h01_01_02_02_03_03_04_04};
    tbl[4] = '{2, 64'h02_02_03_03_04_04_05_05};
    tbl[5] = '{2, 64'h02_02_03_03_04_04_05_05};

    rst = 1'b1;
    a_v = 1'b0;
    a_d = '0;
    b_v = 1'b0;
    b_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("a_rst_blank", a_bl, 1);
    check("a_rst_ready", a_rdy, 1);
    check("a_rst_vo", a_vo, 0);
    check("a_rst_do", a_do, 0);
    check("b_rst_blank", b_bl, 1);
    check("b_rst_ready", b_rdy, 1);
    check("b_rst_vo", b_vo, 0);
    check("b_rst_do", b_do, 0);

    frame_a(0, -1, ff, hb, tmo);
    check("held_tmo", tmo, 0);
    cmp_frame("held", 1'b1);
    check("held_ff_driven", ff > 0, 1);
    check("held_hold", hb, 0);
    @(negedge clk);
    check("held_blank_end", a_bl, 1);
    check("held_vo_end", a_vo, 0);

    frame_a(1, -1, ff, hb, tmo);
    check("tog_tmo", tmo, 0);
    cmp_frame("tog", 1'b0);
    check("tog_hold", hb, 0);

    frame_a(2, -1, ff, hb, tmo);
    check("gap3_tmo", tmo, 0);
    cmp_frame("gap3", 1'b0);
    check("gap3_hold", hb, 0);
    @(negedge clk);
    check("gap3_blank_end", a_bl, 1);

    frame_a(0, 7, ff, hb, tmo);
    check("mid_tmo", tmo, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_blank", a_bl, 1);
    check("mid_rst_vo", a_vo, 0);
    check("mid_rst_ready", a_rdy, 1);
    check("mid_rst_do", a_do, 0);
    frame_a(0, -1, ff, hb, tmo);
    check("post_tmo", tmo, 0);
    cmp_frame("post", 1'b1);

    rand_b(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
